mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the mips32 core. It sits in the execute stage directly downstream of the register file and consumes `rsData`/`rtData` for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes `busy` so the hazard logic can stall MFHI/MFLO and new mult/div issues until a result is committed.

## Interface
- No parameters; datapath fixed at 32 bits (64-bit product).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rsData`  in  32  operand A (multiplicand/dividend).
- `rtData`  in  32  operand B (multiplier/divisor).
- `mthi`  in  1  write `rsData` to HI.
- `mtlo`  in  1  write `rsData` to LO.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when HI/LO commit.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE → MUL or DIV → FIX → IDLE.
- IDLE + `start`: latch `op` and operands. For signed ops, store magnitudes plus sign flags. Clear the iteration counter. Go to MUL (op 0x) or DIV (op 1x).
- MUL: 32 shift-add iterations, one per cycle, over unsigned magnitudes into a 64-bit accumulator. After the 32nd iteration go to FIX.
- DIV: 32 restoring-division iterations, one per cycle, over magnitudes. After the 32nd iteration go to FIX.
- FIX sign rules:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ.
  - DIV: give the remainder the sign of the dividend.
- FIX commit: HI = product[63:32] / remainder; LO = product[31:0] / quotient. Pulse `done`, return to IDLE.
- Divide by zero (divisor latched as 0, any signedness): HI = original `rsData`, LO = 32'hFFFFFFFF. No sign fix. Normal latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of magnitude arithmetic.
- `mthi`/`mtlo` in IDLE without `start`: write HI/LO at the next edge. Both may be asserted together.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins; the moves are dropped.
- `start`, `mthi`, `mtlo` while `busy`: ignored; the operation in flight is unaffected.
- Operands may change after the start edge; only latched values are used.

## Timing
- Edge E0 samples `start`. Edges E1–E32 perform the iterations. Edge E33 executes FIX.
- `busy` is high after E0 through the cycle ending at E33.
- `done` is high and `hi`/`lo` are valid in the cycle after E33: 33 cycles after the start edge.
- `busy` is low in the `done` cycle, so a new `start` is accepted there (back-to-back issue).
- `hi`/`lo` hold their previous values throughout the operation.
- MTHI/MTLO latency: one edge.
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE, counter 0.
- Reset mid-operation: the operation is aborted with no commit. All outputs take their reset values at that edge.
- Reset has priority over `start`, `mthi` and `mtlo`.

## Configuration
- `MULTDIV_FAST_MUL_EN` defined: MULT/MULTU compute the 64-bit product in one cycle with a combinational multiplier.
  - MUL state lasts one cycle, so FIX runs at E2.
  - `done` is asserted 2 cycles after the start edge.
  - Division is unchanged.
- Not defined: iterative multiply with 33-cycle latency as specified above; no hardware multiplier is inferred.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `done` exactly 33 cycles after start (2 with the macro). `busy` high for the whole interval.
- Signed cases:
  - MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 100 / 7 → LO = 14, HI = 2.
- Divide edge cases:
  - DIV 0x12345678 / 0 → HI = 0x12345678, LO = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Blocking and priority:
  - Second `start`, `mthi` and operand changes while busy → ignored; first result is correct.
  - MTHI 0xDEADBEEF in IDLE → `hi` = 0xDEADBEEF after one edge.
  - `start` + `mtlo` in the same cycle → `mtlo` dropped.
- Back-to-back issue: `start` in the `done` cycle is accepted, and the second result commits 33 cycles later.
- Reset mid-operation: `rst` at iteration 10 → `busy` = 0, `hi` = `lo` = 0, no `done` pulse. A following MULTU 6 × 7 gives LO = 42, HI = 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit with the architectural HI/LO registers of the
// mips32 core. MULT/MULTU use a 32-step shift-add multiplier and DIV/DIVU use a
// 32-step restoring divider, both over operand magnitudes. A FIX state applies
// the sign rules and commits HI/LO. MTHI/MTLO write HI/LO directly while idle.
//
// Optional feature macro: MULTDIV_FAST_MUL_EN
//   defined     -> MULT/MULTU use a single-cycle combinational multiplier
//                  (result committed 2 cycles after the start edge).
//   not defined -> iterative multiply, 33-cycle latency, no hardware multiplier.
//
// Ports
//   clk     in   1   clock, rising edge
//   rst     in   1   synchronous active-high reset
//   start   in   1   issue request, sampled only in IDLE
//   op      in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rsData  in  32   operand A (multiplicand / dividend), MTHI/MTLO data
//   rtData  in  32   operand B (multiplier / divisor)
//   mthi    in   1   write rsData to HI (IDLE only, start has priority)
//   mtlo    in   1   write rsData to LO (IDLE only, start has priority)
//   busy    out  1   high whenever the unit is not idle
//   done    out  1   one-cycle pulse in the cycle after HI/LO commit
//   hi      out 32   HI register
//   lo      out 32   LO register
// -----------------------------------------------------------------------------
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [4:0]  count;

    // Shared 64-bit working register.
    //   MUL: {partial product high, remaining multiplier / product low}
    //   DIV: {partial remainder, dividend bits shifting out / quotient bits in}
    logic [63:0] acc;

    // Operand preparation at issue: signed ops (op[0] == 0) keep magnitudes
    // plus sign flags; unsigned ops never set a sign flag.
    logic        in_sign_a;
    logic        in_sign_b;
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;

    assign in_sign_a = ~op[0] & rsData[31];
    assign in_sign_b = ~op[0] & rtData[31];
    assign in_a_mag  = in_sign_a ? -rsData : rsData;
    assign in_b_mag  = in_sign_b ? -rtData : rtData;

    // Original operand A, rebuilt from magnitude and sign; two's complement
    // negation round-trips even for 0x80000000.
    logic [31:0] a_orig;
    assign a_orig = sign_a ? -a_mag : a_mag;

`ifndef MULTDIV_FAST_MUL_EN
    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, then shift everything right.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
`endif

    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits. The partial remainder is
    // always below the divisor, so the difference fits in 32 bits.
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_sub;

    assign div_shift = {acc[63:32], acc[31]};
    assign div_ok    = (div_shift >= {1'b0, b_mag});
    assign div_sub   = div_shift[31:0] - b_mag;

    // Sign fix-up and commit values.
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        fix_hi = acc[63:32];
        fix_lo = acc[31:0];
        if (!op_q[1]) begin
            if (sign_a ^ sign_b) begin
                {fix_hi, fix_lo} = -acc;
            end
        end else if (b_mag == 32'd0) begin
            // Divide by zero: HI returns the dividend, LO all ones, no sign fix.
            fix_hi = a_orig;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            if (sign_a ^ sign_b) begin
                fix_lo = -acc[31:0];
            end
            if (sign_a) begin
                fix_hi = -acc[63:32];
            end
        end
    end

    assign busy = (state != IDLE);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 2'd0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_mag  <= 32'd0;
            b_mag  <= 32'd0;
            acc    <= 64'd0;
            count  <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        a_mag  <= in_a_mag;
                        b_mag  <= in_b_mag;
                        count  <= 5'd0;
                        acc    <= op[1] ? {32'd0, in_a_mag} : {32'd0, in_b_mag};
                        state  <= op[1] ? DIV : MUL;
                    end else begin
                        if (mthi) hi <= rsData;
                        if (mtlo) lo <= rsData;
                    end
                end

                MUL: begin
`ifdef MULTDIV_FAST_MUL_EN
                    acc   <= {32'd0, a_mag} * {32'd0, b_mag};
                    state <= FIX;
`else
                    acc   <= {mul_sum, acc[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
`endif
                end

                DIV: begin
                    acc   <= {(div_ok ? div_sub : div_shift[31:0]), acc[30:0], div_ok};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end

                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit. Expected HI/LO come from a reference
// model using plain 64-bit integer arithmetic (MIPS truncating division,
// divide-by-zero returns the dividend in HI and all ones in LO). Latency,
// busy, hold, priority, back-to-back and reset behaviour are checked directly.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passed = 0;

    // Architectural HI/LO as the bench expects them.
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rsData (rsData),
        .rtData (rtData),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Reference model: returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                q   = sa * sb;
                res = q;
            end
            2'b01: res = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    // Issue one operation and follow it to its commit.
    //   disturb      : assert start/mthi/mtlo with new data while busy
    //   mt_with_start: assert mthi/mtlo in the same cycle as start
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input bit mt_with_start);
        logic [63:0] e;
        int          lat;
        int          n;
        bit          seen;
        bit          busy_ok;
        bit          hold_ok;
        e   = model(o, a, b);
        lat = 33;
`ifdef MULTDIV_FAST_MUL_EN
        if (!o[1]) lat = 2;
`endif
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rsData = a;
        rtData = b;
        mthi   = mt_with_start;
        mtlo   = mt_with_start;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        op     = 2'($urandom);
        rsData = $urandom;
        rtData = $urandom;
        check({tag, " done_low_after_start"}, 64'(done), 64'd0);

        n       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!seen && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
            if (disturb && n >= 3 && n <= 5) begin
                start  = 1'b1;
                mthi   = 1'b1;
                mtlo   = 1'b1;
                op     = 2'($urandom);
                rsData = $urandom;
                rtData = $urandom;
            end else begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;

        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy_during_op"}, 64'(busy_ok), 64'd1);
        check({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
        check({tag, " busy_low_in_done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        exp_hi = e[63:32];
        exp_lo = e[31:0];
    endtask

    initial begin
        int          pulses;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        rsData = 32'd0;
        rtData = 32'd0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst = 1'b0;

        // Directed cases.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mult_neg", 2'b00, -32'sd3, 32'd7, 1'b0, 1'b0);
        run_op("div_neg", 2'b10, -32'sd7, 32'd2, 1'b0, 1'b0);
        run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("div_by_zero", 2'b10, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op("divu_by_zero", 2'b11, 32'h8765_4321, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_neg_by_zero", 2'b10, 32'hF000_0001, 32'd0, 1'b0, 1'b0);

        // Activity while busy is ignored.
        run_op("div_disturbed", 2'b10, 32'd1000, -32'sd33, 1'b1, 1'b0);
        run_op("multu_disturbed", 2'b01, 32'h0001_0003, 32'h0F00_00F1, 1'b1, 1'b0);

        // start together with moves: moves dropped (checked by hilo_hold).
        run_op("start_with_mt", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);

        // MTHI, then MTHI+MTLO together, one-edge latency.
        @(negedge clk);
        mthi   = 1'b1;
        rsData = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
        check("mthi lo_unchanged", 64'(lo), 64'(exp_lo));
        exp_hi = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi   = 1'b1;
        mtlo   = 1'b1;
        rsData = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo hi", 64'(hi), 64'h0000_0000_CAFE_F00D);
        check("mthi_mtlo lo", 64'(lo), 64'h0000_0000_CAFE_F00D);
        exp_hi = 32'hCAFE_F00D;
        exp_lo = 32'hCAFE_F00D;

        // Back-to-back issue: each run_op after the first issues in the
        // previous done cycle; a pair here makes that explicit.
        run_op("b2b_first", 2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0);
        run_op("b2b_second", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Randomized operations, every few with a zero divisor.
        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
            run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0, 1'b0);
        end

        // Reset mid-operation: abort with no commit.
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rsData = $urandom;
        rtData = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        rst    = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("midreset no_done", 64'(pulses), 64'd0);
        run_op("after_reset", 2'b01, 32'd6, 32'd7, 1'b0, 1'b0);
        check("after_reset lo42", 64'(lo), 64'd42);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
